// File: rtl/comb_sched_ctrl.sv
// Scheduler for the GCN combination phase: walks output rows and accumulation
// columns, gates the MAC array (clear / accumulate) and hands each finished row
// to the result memory with a valid/ready write-back handshake.
module comb_sched_ctrl #(
   parameter int unsigned NUM_ROWS = 6,
   parameter int unsigned NUM_COLS = 6,
   parameter int unsigned ROW_W    = 3,
   parameter int unsigned COL_W    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             rd_valid,
   input  logic             wr_ready,
   output logic [ROW_W-1:0] row_addr,
   output logic [COL_W-1:0] col_addr,
   output logic             rd_req,
   output logic             mac_clr,
   output logic             mac_en,
   output logic             wr_valid,
   output logic             busy,
   output logic             done,
   output logic             done_lvl,
   output logic [2:0]       state_o
);

   localparam int unsigned ROW_LAST = NUM_ROWS - 1;
   localparam int unsigned COL_LAST = NUM_COLS - 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_ROW = 3'd1,
      S_ACCUM    = 3'd2,
      S_WRITE    = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic             done_lvl_q, done_lvl_d;
   logic             row_last;
   logic             col_last;

   // Last-index detection on zero-extended counters (no truncation of NUM_*-1)
   assign row_last = (32'(row_q) == ROW_LAST);
   assign col_last = (32'(col_q) == COL_LAST);

   // State, counter and sticky-done registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         done_lvl_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         done_lvl_q <= done_lvl_d;
      end
   end

   // Next-state and counter update; abort overrides every transition
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      done_lvl_d = done_lvl_q;
      if (abort) begin
         state_d    = S_IDLE;
         row_d      = '0;
         col_d      = '0;
         done_lvl_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_LOAD_ROW;
                  row_d      = '0;
                  col_d      = '0;
                  done_lvl_d = 1'b0;
               end
            end
            S_LOAD_ROW: begin
               col_d   = '0;
               state_d = S_ACCUM;
            end
            S_ACCUM: begin
               if (rd_valid) begin
                  if (col_last) begin
                     state_d = S_WRITE;
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end
            end
            S_WRITE: begin
               if (wr_ready) begin
                  if (row_last) begin
                     state_d = S_DONE;
                  end else begin
                     row_d   = row_q + ROW_W'(1);
                     state_d = S_LOAD_ROW;
                  end
               end
            end
            S_DONE: begin
               done_lvl_d = 1'b1;
               state_d    = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Control strobes decoded from the registered state
   assign busy     = (state_q != S_IDLE);
   assign mac_clr  = (state_q == S_LOAD_ROW);
   assign rd_req   = (state_q == S_ACCUM);
   assign mac_en   = (state_q == S_ACCUM) && rd_valid;
   assign wr_valid = (state_q == S_WRITE);
   assign done     = (state_q == S_DONE);
   assign done_lvl = done_lvl_q;
   assign row_addr = row_q;
   assign col_addr = col_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_comb_sched_ctrl.sv
// Directed bench for comb_sched_ctrl: scoreboards of expected MAC beats and
// write-back rows, plus a 1x1 instance for the degenerate configuration.
module tb_comb_sched_ctrl;

   localparam int unsigned NR = 6;
   localparam int unsigned NC = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, abort, rd_valid, wr_ready;
   logic [2:0] row_addr, col_addr, state_o;
   logic       rd_req, mac_clr, mac_en, wr_valid, busy, done, done_lvl;

   logic       start1, abort1, rd_valid1, wr_ready1;
   logic [0:0] row_addr1, col_addr1;
   logic [2:0] state_o1;
   logic       rd_req1, mac_clr1, mac_en1, wr_valid1, busy1, done1, done_lvl1;

   always #5 clk = ~clk;

   comb_sched_ctrl #(.NUM_ROWS(NR), .NUM_COLS(NC), .ROW_W(3), .COL_W(3)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .rd_valid(rd_valid), .wr_ready(wr_ready),
      .row_addr(row_addr), .col_addr(col_addr), .rd_req(rd_req),
      .mac_clr(mac_clr), .mac_en(mac_en), .wr_valid(wr_valid),
      .busy(busy), .done(done), .done_lvl(done_lvl), .state_o(state_o)
   );

   comb_sched_ctrl #(.NUM_ROWS(1), .NUM_COLS(1), .ROW_W(1), .COL_W(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .abort(abort1),
      .rd_valid(rd_valid1), .wr_ready(wr_ready1),
      .row_addr(row_addr1), .col_addr(col_addr1), .rd_req(rd_req1),
      .mac_clr(mac_clr1), .mac_en(mac_en1), .wr_valid(wr_valid1),
      .busy(busy1), .done(done1), .done_lvl(done_lvl1), .state_o(state_o1)
   );

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] c;
   } beat_t;

   beat_t      exp_beat[$];
   logic [2:0] exp_row[$];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc, n_en, n_clr, n_wr, n_done, n_unexp, done_cyc, stall_cnt, n_row2_wv;
   logic [2:0] row_at_done, prev_col, prev_row;
   logic       prev_acc_stall, prev_wr_acc;

   // One comparison point
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Per-cycle monitor against the scoreboards
   task automatic sample();
      beat_t b;
      if (prev_acc_stall && state_o == 3'd2)
         check("col_hold_on_stall", 32'(col_addr), 32'(prev_col));
      if (prev_wr_acc) begin
         check("after_write_state", 32'(state_o), 32'd1);
         check("after_write_row", 32'(row_addr), 32'(prev_row + 3'd1));
      end
      if (mac_en) begin
         n_en++;
         if (exp_beat.size() == 0) n_unexp++;
         else begin
            b = exp_beat.pop_front();
            check("mac_row", 32'(row_addr), 32'(b.r));
            check("mac_col", 32'(col_addr), 32'(b.c));
         end
      end
      if (mac_clr) n_clr++;
      if (wr_valid && row_addr == 3'd2) n_row2_wv++;
      if (wr_valid && wr_ready) begin
         n_wr++;
         if (exp_row.size() == 0) n_unexp++;
         else check("wr_row", 32'(row_addr), 32'(exp_row.pop_front()));
      end
      if (done) begin
         n_done++;
         done_cyc    = cyc;
         row_at_done = row_addr;
      end
      prev_acc_stall = (state_o == 3'd2) && !rd_valid && !abort && !reset;
      prev_col       = col_addr;
      prev_wr_acc    = wr_valid && wr_ready && (32'(row_addr) < NR - 1) && !abort && !reset;
      prev_row       = row_addr;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_sb();
      exp_beat.delete();
      exp_row.delete();
      n_en = 0; n_clr = 0; n_wr = 0; n_done = 0; n_unexp = 0;
      done_cyc = -1; n_row2_wv = 0; prev_acc_stall = 1'b0; prev_wr_acc = 1'b0;
   endtask

   // Load the expected run into the scoreboards and pulse start (edge 0)
   task automatic start_run();
      beat_t b;
      clear_sb();
      for (int r = 0; r < int'(NR); r++) begin
         for (int c = 0; c < int'(NC); c++) begin
            b.r = 3'(r);
            b.c = 3'(c);
            exp_beat.push_back(b);
         end
         exp_row.push_back(3'(r));
      end
      rd_valid = 1'b1;
      wr_ready = 1'b1;
      start    = 1'b1;
      cyc      = 0;
      tick();
      start = 1'b0;
   endtask

   task automatic drive_inputs(input int rd_mode, input int stall_row);
      rd_valid = (rd_mode == 0) ? 1'b1 : 1'(cyc % 2);
      if (state_o == 3'd3 && int'(row_addr) == stall_row && stall_cnt < 3) begin
         wr_ready = 1'b0;
         stall_cnt++;
      end else begin
         wr_ready = 1'b1;
      end
   endtask

   task automatic run_to_done(input int rd_mode, input int stall_row, input int budget);
      stall_cnt = 0;
      for (int i = 0; i < budget && n_done == 0; i++) begin
         drive_inputs(rd_mode, stall_row);
         tick();
      end
      rd_valid = 1'b1;
      wr_ready = 1'b1;
   endtask

   task automatic end_checks(input string tag, input int exp_done_cyc);
      check({tag, "_mac_en_count"}, 32'(n_en), NR * NC);
      check({tag, "_mac_clr_count"}, 32'(n_clr), NR);
      check({tag, "_write_count"}, 32'(n_wr), NR);
      check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
      check({tag, "_unexpected"}, 32'(n_unexp), 32'd0);
      check({tag, "_beats_left"}, 32'(exp_beat.size()), 32'd0);
      check({tag, "_rows_left"}, 32'(exp_row.size()), 32'd0);
      check({tag, "_row_at_done"}, 32'(row_at_done), NR - 1);
      if (exp_done_cyc >= 0) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
      check({tag, "_idle_after"}, 32'(state_o), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_done_lvl_set"}, 32'(done_lvl), 32'd1);
      tick();
      tick();
      check({tag, "_done_lvl_holds"}, 32'(done_lvl), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      logic pulsed;
      reset = 1'b1;
      start = 1'b0; abort = 1'b0; rd_valid = 1'b0; wr_ready = 1'b0;
      start1 = 1'b0; abort1 = 1'b0; rd_valid1 = 1'b1; wr_ready1 = 1'b1;
      cyc = 0;
      clear_sb();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_outputs", 32'({row_addr, col_addr, rd_req, mac_clr, mac_en, wr_valid, busy, done, done_lvl}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Full-rate run
      start_run();
      run_to_done(0, -1, 200);
      end_checks("full", 49);

      // Read stalls on alternate cycles
      start_run();
      check("start_clears_done_lvl", 32'(done_lvl), 32'd0);
      run_to_done(1, -1, 400);
      end_checks("rdstall", -1);

      // Write-back backpressure at row 2
      start_run();
      run_to_done(0, 2, 200);
      check("wr_hold_row2_cycles", 32'(n_row2_wv), 32'd4);
      end_checks("wrstall", 52);

      // Abort in ACCUM at row 3 col 4
      start_run();
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         drive_inputs(0, -1);
         if (state_o == 3'd2 && row_addr == 3'd3 && col_addr == 3'd4) found = 1'b1;
         else tick();
      end
      check("abort_point_found", 32'(found), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_state", 32'(state_o), 32'd0);
      check("abort_counters", 32'({row_addr, col_addr}), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done_lvl", 32'(done_lvl), 32'd0);
      tick();
      tick();
      check("abort_no_done", 32'(n_done), 32'd0);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("abort_beats_start", 32'(state_o), 32'd0);
      start_run();
      run_to_done(0, -1, 200);
      end_checks("rerun", 49);

      // start pulsed during ACCUM is ignored
      start_run();
      pulsed = 1'b0;
      for (int i = 0; i < 200 && n_done == 0; i++) begin
         drive_inputs(0, -1);
         if (!pulsed && state_o == 3'd2 && row_addr == 3'd1) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         tick();
         start = 1'b0;
      end
      check("busy_start_pulsed", 32'(pulsed), 32'd1);
      end_checks("busystart", 49);

      // Asynchronous reset in the middle of a write-back
      start_run();
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         drive_inputs(0, -1);
         if (state_o == 3'd3 && row_addr == 3'd2) found = 1'b1;
         else tick();
      end
      check("write_point_found", 32'(found), 32'd1);
      wr_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("rst_mid_state", 32'(state_o), 32'd0);
      check("rst_mid_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_mid_outputs", 32'({row_addr, col_addr, rd_req, mac_clr, mac_en, busy, done, done_lvl}), 32'd0);
      tick();
      reset = 1'b0;
      wr_ready = 1'b1;
      tick();
      tick();
      check("rst_mid_no_done", 32'(n_done), 32'd0);
      check("rst_mid_idle", 32'(state_o), 32'd0);

      // 1x1 configuration: LOAD, ACCUM, WRITE, DONE
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("one_state", 32'(state_o1), 32'(k));
         check("one_done", 32'(done1), 32'(k == 4));
         check("one_mac_en", 32'(mac_en1), 32'(k == 2));
         check("one_wr_valid", 32'(wr_valid1), 32'(k == 3));
         @(posedge clk);
         #1;
      end
      check("one_done_lvl", 32'(done_lvl1), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("one_done_lvl_holds", 32'(done_lvl1), 32'd1);
      check("one_idle", 32'(busy1), 32'd0);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      check("one_restart_clears", 32'(done_lvl1), 32'd0);
      check("one_restart_state", 32'(state_o1), 32'd1);
      repeat (5) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
